// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the shift-add signed multiplier controller.
// Provides the FSM state encoding and the default operand width.
package mult_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD,
        SHIFT,
        HALT
    } state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer.
// Ports: clk, rst (async, active-high), clr/inc (sync), count, last.
module mult_iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_control.sv
// Sequencing FSM for the shift-add signed multiplier (X:A:B datapath).
// Ports: Clk, Reset, Run, ClearA_LoadB, M in; Clr_Ld, Clr_XA, Add, Sub,
// Ld_X, Shift, Busy, Done out (all combinational from state, M, count).
module mult_seq_control
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Ld_X,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             last;
    logic [CNT_W-1:0] count;

    mult_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        Clr_Ld     = 1'b0;
        Clr_XA     = 1'b0;
        Add        = 1'b0;
        Sub        = 1'b0;
        Ld_X       = 1'b0;
        Shift      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                // Run wins, but the load strobe still follows the switch
                Clr_Ld = ClearA_LoadB;
                if (Run) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                Busy       = 1'b1;
                Clr_XA     = 1'b1;
                cnt_clr    = 1'b1;
                state_next = ADD;
            end
            ADD: begin
                Busy = 1'b1;
                // MSB of a two's-complement multiplier has negative weight
                if (M) begin
                    Ld_X = 1'b1;
                    if (last) begin
                        Sub = 1'b1;
                    end else begin
                        Add = 1'b1;
                    end
                end
                state_next = SHIFT;
            end
            SHIFT: begin
                Busy  = 1'b1;
                Shift = 1'b1;
                if (last) begin
                    state_next = HALT;
                end else begin
                    cnt_inc    = 1'b1;
                    state_next = ADD;
                end
            end
            HALT: begin
                Done = 1'b1;
                // Wait for Run release so a held switch cannot re-trigger
                if (!Run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_control.sv
// Self-checking bench for mult_seq_control (WIDTH = 8).
// Expected strobe vectors are queued per sequence and popped each cycle.
module tb_mult_seq_control;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clr_Ld;
    logic Clr_XA;
    logic Add;
    logic Sub;
    logic Ld_X;
    logic Shift;
    logic Busy;
    logic Done;

    logic [7:0] obs;
    logic [7:0] q[$];
    int passed = 0;
    int total  = 0;

    mult_seq_control #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .Clr_XA       (Clr_XA),
        .Add          (Add),
        .Sub          (Sub),
        .Ld_X         (Ld_X),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    // {Clr_Ld, Clr_XA, Add, Sub, Ld_X, Shift, Busy, Done}
    assign obs = {Clr_Ld, Clr_XA, Add, Sub, Ld_X, Shift, Busy, Done};

    // Reference sequence for multiplier b: CLEAR, W x (ADD, SHIFT), HALT.
    task automatic push_seq(input logic [W-1:0] b);
        q.push_back(8'b0100_0010);
        for (int k = 0; k < W; k++) begin
            if (!b[k]) begin
                q.push_back(8'b0000_0010);
            end else if (k == W - 1) begin
                q.push_back(8'b0001_1010);
            end else begin
                q.push_back(8'b0010_1010);
            end
            q.push_back(8'b0000_0110);
        end
        q.push_back(8'b0000_0001);
    endtask

    // M is modelled as the LSB of B, advancing on every Shift pulse.
    task automatic run_seq(
        input  logic [W-1:0] b,
        input  logic         hold,
        input  logic         cab,
        input  string        nm,
        output int           adds,
        output int           subs,
        output int           shifts,
        output int           clrs
    );
        int         ns;
        int         cyc;
        logic [7:0] e;
        ns     = 0;
        cyc    = 0;
        adds   = 0;
        subs   = 0;
        shifts = 0;
        clrs   = 0;
        @(negedge Clk);
        Run          = 1'b1;
        ClearA_LoadB = cab;
        M            = b[0];
        #1;
        total++;
        if (obs !== {cab, 7'b0})
            $display("FAIL %s idle_run: got %b exp %b", nm, obs, {cab, 7'b0});
        else
            passed++;
        push_seq(b);
        while (q.size() > 0) begin
            @(negedge Clk);
            Run          = hold;
            ClearA_LoadB = cab;
            M            = (ns < W) ? b[ns] : 1'b0;
            #1;
            cyc++;
            e = q.pop_front();
            total++;
            if (obs !== e)
                $display("FAIL %s edge%0d: got %b exp %b", nm, cyc, obs, e);
            else
                passed++;
            total++;
            if ($countones({Clr_XA, Add, Sub, Shift}) > 1 ||
                (Ld_X && !(Add || Sub)))
                $display("FAIL %s onehot edge%0d: got %b", nm, cyc, obs);
            else
                passed++;
            adds   += int'(Add);
            subs   += int'(Sub);
            clrs   += int'(Clr_XA);
            shifts += int'(Shift);
            if (Shift) ns++;
        end
    endtask

    task automatic test_reset();
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        M            = 1'b0;
        #2;
        total++;
        if (obs !== 8'h00)
            $display("FAIL reset_outs: got %b exp %b", obs, 8'h00);
        else
            passed++;
        ClearA_LoadB = 1'b1;
        #1;
        total++;
        if (obs !== 8'b1000_0000)
            $display("FAIL reset_clrld: got %b exp %b", obs, 8'b1000_0000);
        else
            passed++;
        @(negedge Clk);
        Reset        = 1'b0;
        ClearA_LoadB = 1'b0;
    endtask

    task automatic test_reset_mid();
        int a, s, sh, c;
        @(negedge Clk);
        Run = 1'b1;
        M   = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        repeat (7) @(negedge Clk);
        #1;
        total++;
        if (obs !== 8'b0010_1010 || dut.count !== 3'd3)
            $display("FAIL mid_add3: got %b cnt %0d exp %b cnt 3",
                     obs, dut.count, 8'b0010_1010);
        else
            passed++;
        Reset = 1'b1;
        #1;
        total++;
        if (obs !== 8'h00)
            $display("FAIL mid_reset: got %b exp %b", obs, 8'h00);
        else
            passed++;
        @(negedge Clk);
        Reset = 1'b0;
        run_seq(8'hFF, 1'b0, 1'b0, "restart", a, s, sh, c);
        total++;
        if (a !== 7 || s !== 1 || sh !== 8 || c !== 1)
            $display("FAIL restart_counts: got a%0d s%0d sh%0d c%0d exp 7 1 8 1",
                     a, s, sh, c);
        else
            passed++;
        @(negedge Clk);
        Run = 1'b0;
    endtask

    task automatic test_clr_ld();
        int a, s, sh, c;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            ClearA_LoadB = 1'b1;
            #1;
            total++;
            if (obs !== 8'b1000_0000)
                $display("FAIL clrld_idle%0d: got %b exp %b",
                         i, obs, 8'b1000_0000);
            else
                passed++;
        end
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        #1;
        total++;
        if (obs !== 8'h00)
            $display("FAIL clrld_release: got %b exp %b", obs, 8'h00);
        else
            passed++;
        run_seq(8'h2C, 1'b0, 1'b1, "clrld_busy", a, s, sh, c);
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        Run = 1'b0;
    endtask

    task automatic test_b07();
        int a, s, sh, c;
        run_seq(8'h07, 1'b0, 1'b0, "b07", a, s, sh, c);
        total++;
        if (a !== 3 || s !== 0 || sh !== 8 || c !== 1)
            $display("FAIL b07_counts: got a%0d s%0d sh%0d c%0d exp 3 0 8 1",
                     a, s, sh, c);
        else
            passed++;
        @(negedge Clk);
        Run = 1'b0;
    endtask

    task automatic test_b80();
        int a, s, sh, c;
        run_seq(8'h80, 1'b0, 1'b0, "b80", a, s, sh, c);
        total++;
        if (a !== 0 || s !== 1 || sh !== 8 || c !== 1)
            $display("FAIL b80_counts: got a%0d s%0d sh%0d c%0d exp 0 1 8 1",
                     a, s, sh, c);
        else
            passed++;
        @(negedge Clk);
        Run = 1'b0;
    endtask

    task automatic test_back_to_back();
        int a, s, sh, c;
        run_seq(8'h5A, 1'b1, 1'b0, "hold", a, s, sh, c);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            Run = 1'b1;
            #1;
            total++;
            if (obs !== 8'b0000_0001)
                $display("FAIL hold_halt%0d: got %b exp %b",
                         i, obs, 8'b0000_0001);
            else
                passed++;
        end
        Run = 1'b0;
        @(negedge Clk);
        #1;
        total++;
        if (obs !== 8'h00)
            $display("FAIL hold_release: got %b exp %b", obs, 8'h00);
        else
            passed++;
        run_seq(8'h81, 1'b0, 1'b0, "rerun", a, s, sh, c);
        total++;
        if (a !== 1 || s !== 1 || sh !== 8 || c !== 1)
            $display("FAIL rerun_counts: got a%0d s%0d sh%0d c%0d exp 1 1 8 1",
                     a, s, sh, c);
        else
            passed++;
        @(negedge Clk);
        Run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_clr_ld();
        test_b07();
        test_b80();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
